// File: rtl/job_dispatcher_pkg.sv
// Shared parameters, payload types and helpers for the job dispatcher.
package job_dispatcher_pkg;

  localparam int unsigned NUM_JOB_PE           = 4;
  localparam int unsigned HASH_ISSUE_WIDTH     = 4;
  localparam int unsigned JOB_LEN              = 16;
  localparam int unsigned ADDR_WIDTH           = 32;
  localparam int unsigned META_MATCH_LEN_WIDTH = 5;

  localparam int unsigned BATCHES_PER_JOB = JOB_LEN / HASH_ISSUE_WIDTH;
  localparam int unsigned BATCH_CNT_W     = $clog2(BATCHES_PER_JOB);
  localparam int unsigned PE_IDX_W        = $clog2(NUM_JOB_PE);
  localparam int unsigned HIST_ADDR_W     = HASH_ISSUE_WIDTH * ADDR_WIDTH;
  localparam int unsigned META_LEN_W      = HASH_ISSUE_WIDTH * META_MATCH_LEN_WIDTH;

  typedef logic [PE_IDX_W-1:0]    pe_idx_t;
  typedef logic [BATCH_CNT_W-1:0] batch_cnt_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  // One hash batch as it travels from the hash stage to a job_pe.
  typedef struct packed {
    addr_t                       head_addr;
    logic [HASH_ISSUE_WIDTH-1:0] history_valid;
    logic [HIST_ADDR_W-1:0]      history_addr;
    logic [META_LEN_W-1:0]       meta_match_len;
    logic [HASH_ISSUE_WIDTH-1:0] meta_match_can_ext;
    logic                        delim;
  } hash_batch_t;

  // Output slot contents: the batch plus the PE it is steered to.
  typedef struct packed {
    pe_idx_t     tgt;
    hash_batch_t batch;
  } slot_t;

  // Head address that batch idx of a job must carry; wraps at ADDR_WIDTH.
  function automatic addr_t expected_head(input addr_t job_head, input batch_cnt_t idx);
    addr_t offset;
    offset = ADDR_WIDTH'(idx) * ADDR_WIDTH'(HASH_ISSUE_WIDTH);
    return job_head + offset;
  endfunction

endpackage

// File: rtl/job_dispatcher_if.sv
// Hash-batch stream bus: N_VALID valid/ready lanes sharing one data bus.
interface job_dispatcher_if
  import job_dispatcher_pkg::*;
#(
  parameter int unsigned N_VALID = 1
) ();

  logic [N_VALID-1:0]          valid;
  logic [N_VALID-1:0]          ready;
  addr_t                       head_addr;
  logic [HASH_ISSUE_WIDTH-1:0] history_valid;
  logic [HIST_ADDR_W-1:0]      history_addr;
  logic [META_LEN_W-1:0]       meta_match_len;
  logic [HASH_ISSUE_WIDTH-1:0] meta_match_can_ext;
  logic                        delim;

  modport master (
    output valid,
    output head_addr,
    output history_valid,
    output history_addr,
    output meta_match_len,
    output meta_match_can_ext,
    output delim,
    input  ready
  );

  modport slave (
    input  valid,
    input  head_addr,
    input  history_valid,
    input  history_addr,
    input  meta_match_len,
    input  meta_match_can_ext,
    input  delim,
    output ready
  );

endinterface

// File: rtl/job_dispatcher_reg_slice.sv
// Hash-batch register slice: single-entry valid/ready slot with a
// parameterised payload. Accepts a new entry in the same cycle the held
// one drains, so it sustains one transfer per cycle.
module job_dispatcher_reg_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready_c,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic load_c;

  // Slot can take a new entry when empty or when the held entry leaves now.
  assign in_ready_c = !out_valid || out_ready;
  assign load_c     = in_valid && in_ready_c;

  // Held flag: set on load, cleared on a drain without a reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload register; only changes on load so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (load_c) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/job_dispatcher.sv
// Groups the hash-batch stream into jobs of BATCHES_PER_JOB batches and
// steers whole jobs to the job_pe array in strict round-robin order, with
// sticky checks for address contiguity and delim placement within a job.
module job_dispatcher
  import job_dispatcher_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  job_dispatcher_if.slave          in_bus,
  job_dispatcher_if.master         out_bus,
  output pe_idx_t                  cur_pe,
  output logic                     err_addr,
  output logic                     err_delim
);

  localparam int unsigned SLOT_W = $bits(slot_t);

  batch_cnt_t batch_cnt;
  addr_t      job_head;
  slot_t      in_slot_c;
  slot_t      out_slot;
  logic       slot_valid;
  logic       slot_in_ready_c;
  logic       slot_out_ready_c;
  logic       accept_c;
  logic       last_batch_c;
  logic       addr_err_c;
  logic       delim_err_c;

  // Pack the incoming batch together with the PE that owns the current job.
  always_comb begin
    in_slot_c                          = '0;
    in_slot_c.tgt                      = cur_pe;
    in_slot_c.batch.head_addr          = in_bus.head_addr;
    in_slot_c.batch.history_valid      = in_bus.history_valid;
    in_slot_c.batch.history_addr       = in_bus.history_addr;
    in_slot_c.batch.meta_match_len     = in_bus.meta_match_len;
    in_slot_c.batch.meta_match_can_ext = in_bus.meta_match_can_ext;
    in_slot_c.batch.delim              = in_bus.delim;
  end

  // The held batch drains only on the ready of the PE it is steered to.
  assign slot_out_ready_c = out_bus.ready[out_slot.tgt];

  job_dispatcher_reg_slice #(
    .W (SLOT_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_bus.valid[0]),
    .in_data    (in_slot_c),
    .in_ready_c (slot_in_ready_c),
    .out_valid  (slot_valid),
    .out_data   (out_slot),
    .out_ready  (slot_out_ready_c)
  );

  assign in_bus.ready = slot_in_ready_c;
  assign accept_c     = in_bus.valid[0] && slot_in_ready_c;
  assign last_batch_c = (batch_cnt == batch_cnt_t'(BATCHES_PER_JOB - 1));

  // One-hot valid towards the PE that owns the held batch.
  always_comb begin
    out_bus.valid = '0;
    if (slot_valid) begin
      out_bus.valid[out_slot.tgt] = 1'b1;
    end
  end

  // Shared data bus broadcast to every PE.
  assign out_bus.head_addr          = out_slot.batch.head_addr;
  assign out_bus.history_valid      = out_slot.batch.history_valid;
  assign out_bus.history_addr       = out_slot.batch.history_addr;
  assign out_bus.meta_match_len     = out_slot.batch.meta_match_len;
  assign out_bus.meta_match_can_ext = out_slot.batch.meta_match_can_ext;
  assign out_bus.delim              = out_slot.batch.delim;

  // Protocol checks on the batch being accepted this cycle.
  assign addr_err_c  = (batch_cnt != '0) &&
                       (in_bus.head_addr != expected_head(job_head, batch_cnt));
  assign delim_err_c = in_bus.delim && !last_batch_c;

  // Job position counters: advance the PE only after a job's last batch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      batch_cnt <= '0;
      cur_pe    <= '0;
    end else if (accept_c) begin
      batch_cnt <= batch_cnt + batch_cnt_t'(1);
      if (last_batch_c) begin
        cur_pe <= cur_pe + pe_idx_t'(1);
      end
    end
  end

  // Base address of the current job, captured from its first batch.
  always_ff @(posedge clk) begin
    if (accept_c && (batch_cnt == '0)) begin
      job_head <= in_bus.head_addr;
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_addr  <= 1'b0;
      err_delim <= 1'b0;
    end else if (accept_c) begin
      if (addr_err_c) begin
        err_addr <= 1'b1;
      end
      if (delim_err_c) begin
        err_delim <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_job_dispatcher.sv
// Scoreboard bench for job_dispatcher: directed jobs push expected batches
// into per-PE queues, a monitor pops and compares on every PE handshake.
module tb_job_dispatcher;
  import job_dispatcher_pkg::*;

  localparam int unsigned MAX_WAIT = 200;

  logic    clk = 1'b0;
  logic    rst_n;
  pe_idx_t cur_pe;
  logic    err_addr;
  logic    err_delim;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  job_dispatcher_if #(.N_VALID(1))          in_bus ();
  job_dispatcher_if #(.N_VALID(NUM_JOB_PE)) out_bus ();

  job_dispatcher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .out_bus   (out_bus),
    .cur_pe    (cur_pe),
    .err_addr  (err_addr),
    .err_delim (err_delim)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  hash_batch_t exp_q [NUM_JOB_PE][$];
  pe_idx_t     model_pe  = '0;
  batch_cnt_t  model_cnt = '0;
  logic        rnd_ready = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout required completion", name);
  endtask

  function automatic hash_batch_t out_word();
    hash_batch_t w;
    w.head_addr          = out_bus.head_addr;
    w.history_valid      = out_bus.history_valid;
    w.history_addr       = out_bus.history_addr;
    w.meta_match_len     = out_bus.meta_match_len;
    w.meta_match_can_ext = out_bus.meta_match_can_ext;
    w.delim              = out_bus.delim;
    return w;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_JOB_PE; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Drive one batch, record where it must land, return just after acceptance.
  task automatic send(input addr_t head, input logic delim);
    hash_batch_t b;
    int waited;
    b.head_addr     = head;
    b.history_valid = HASH_ISSUE_WIDTH'($urandom);
    for (int l = 0; l < HASH_ISSUE_WIDTH; l++)
      b.history_addr[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'($urandom);
    b.meta_match_len     = META_LEN_W'($urandom);
    b.meta_match_can_ext = HASH_ISSUE_WIDTH'($urandom);
    b.delim              = delim;
    in_bus.head_addr          = b.head_addr;
    in_bus.history_valid      = b.history_valid;
    in_bus.history_addr       = b.history_addr;
    in_bus.meta_match_len     = b.meta_match_len;
    in_bus.meta_match_can_ext = b.meta_match_can_ext;
    in_bus.delim              = b.delim;
    in_bus.valid              = 1'b1;
    exp_q[model_pe].push_back(b);
    if (model_cnt == batch_cnt_t'(BATCHES_PER_JOB - 1)) model_pe = model_pe + pe_idx_t'(1);
    model_cnt = model_cnt + batch_cnt_t'(1);
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_bus.ready[0]) break;
      waited++;
      if (waited > MAX_WAIT) begin
        fail_now("accept_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_bus.valid = 1'b0;
  endtask

  task automatic send_job(input addr_t base);
    for (int b = 0; b < BATCHES_PER_JOB; b++)
      send(base + addr_t'(b * HASH_ISSUE_WIDTH), 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while (pending() != 0) begin
      @(negedge clk);
      waited++;
      if (waited > MAX_WAIT) begin
        fail_now(name);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every PE handshake against that PE's queue, and check
  // that a stalled batch keeps its valid and data until taken.
  hash_batch_t           got_w;
  hash_batch_t           exp_w;
  hash_batch_t           prev_w;
  logic [NUM_JOB_PE-1:0] prev_valid;
  logic                  prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      got_w = out_word();
      if (prev_stall) begin
        check("hold_valid", 256'(out_bus.valid), 256'(prev_valid));
        check("hold_data", 256'(got_w), 256'(prev_w));
      end
      if (out_bus.valid != '0)
        check("valid_onehot", 256'($onehot(out_bus.valid)), 256'(1));
      for (int i = 0; i < NUM_JOB_PE; i++) begin
        if (out_bus.valid[i] && out_bus.ready[i]) begin
          if (exp_q[i].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pe%0d_extra: got head %0h required no batch", i, got_w.head_addr);
          end else begin
            exp_w = exp_q[i].pop_front();
            check($sformatf("pe%0d_batch", i), 256'(got_w), 256'(exp_w));
          end
        end
      end
      prev_stall = |(out_bus.valid & ~out_bus.ready);
      prev_valid = out_bus.valid;
      prev_w     = got_w;
    end
  end

  // Random per-PE backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_bus.ready = NUM_JOB_PE'($urandom);
    end
  end

  initial begin
    int t0;
    rst_n                      = 1'b0;
    in_bus.valid               = 1'b0;
    in_bus.head_addr           = '0;
    in_bus.history_valid       = '0;
    in_bus.history_addr        = '0;
    in_bus.meta_match_len      = '0;
    in_bus.meta_match_can_ext  = '0;
    in_bus.delim               = 1'b0;
    out_bus.ready              = '1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 256'(out_bus.valid), 256'(0));
    check("rst_cur_pe", 256'(cur_pe), 256'(0));
    check("rst_err_addr", 256'(err_addr), 256'(0));
    check("rst_err_delim", 256'(err_delim), 256'(0));
    check("rst_in_ready", 256'(in_bus.ready), 256'(1));
    @(posedge clk);
    #1;

    // 8 contiguous jobs, full throughput after one cycle of latency.
    send(32'h0, 1'b0);
    check("latency_valid", 256'(out_bus.valid), 256'(4'b0001));
    check("latency_head", 256'(out_bus.head_addr), 256'(0));
    t0 = cycle;
    for (int n = 1; n < 32; n++) send(addr_t'(n * 4), 1'b0);
    check("throughput_cycles", 256'(cycle - t0), 256'(31));
    wait_drain("drain_contig");
    check("contig_err_addr", 256'(err_addr), 256'(0));
    check("contig_err_delim", 256'(err_delim), 256'(0));
    check("contig_cur_pe", 256'(cur_pe), 256'(0));

    // PE1 stalls while holding job 1 batch 2.
    send_job(32'h400);
    send(32'h410, 1'b0);
    send(32'h414, 1'b0);
    send(32'h418, 1'b0);
    out_bus.ready = 4'b1101;
    fork
      begin
        send(32'h41C, 1'b0);
        send_job(32'h420);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          check("stall_in_ready", 256'(in_bus.ready), 256'(0));
          check("stall_valid", 256'(out_bus.valid), 256'(4'b0010));
          check("stall_head", 256'(out_bus.head_addr), 256'(32'h418));
          check("stall_cur_pe", 256'(cur_pe), 256'(1));
        end
        @(posedge clk);
        #1;
        out_bus.ready = '1;
      end
    join
    wait_drain("drain_stall");
    check("stall_cur_pe_after", 256'(cur_pe), 256'(3));

    // Delim on a final batch is legal; on batch 1 it is flagged and sticks.
    send(32'h430, 1'b0);
    send(32'h434, 1'b0);
    send(32'h438, 1'b0);
    send(32'h43C, 1'b1);
    check("delim_final_err", 256'(err_delim), 256'(0));
    send(32'h440, 1'b0);
    send(32'h444, 1'b1);
    check("delim_mid_err", 256'(err_delim), 256'(1));
    send(32'h448, 1'b0);
    send(32'h44C, 1'b0);
    check("delim_sticky", 256'(err_delim), 256'(1));
    check("delim_no_addr_err", 256'(err_addr), 256'(0));

    // Address gap on the third batch of a job on PE1.
    send(32'h100, 1'b0);
    send(32'h104, 1'b0);
    check("addr_ok_b1", 256'(err_addr), 256'(0));
    send(32'h10C, 1'b0);
    check("addr_err_b2", 256'(err_addr), 256'(1));
    send(32'h110, 1'b0);
    check("addr_err_sticky", 256'(err_addr), 256'(1));
    wait_drain("drain_addr");

    // Reset in the middle of a job on PE2.
    send(32'h200, 1'b0);
    send(32'h204, 1'b0);
    send(32'h208, 1'b0);
    check("pre_rst_cur_pe", 256'(cur_pe), 256'(2));
    wait_drain("drain_pre_rst");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_pe  = '0;
    model_cnt = '0;
    check("mid_rst_valid", 256'(out_bus.valid), 256'(0));
    check("mid_rst_cur_pe", 256'(cur_pe), 256'(0));
    check("mid_rst_err_addr", 256'(err_addr), 256'(0));
    check("mid_rst_err_delim", 256'(err_delim), 256'(0));
    send(32'h300, 1'b0);
    check("post_rst_valid", 256'(out_bus.valid), 256'(4'b0001));
    send(32'h304, 1'b0);
    send(32'h308, 1'b0);
    send(32'h30C, 1'b0);
    check("post_rst_cur_pe", 256'(cur_pe), 256'(1));
    wait_drain("drain_post_rst");

    // 250 jobs with random input gaps and random per-PE backpressure.
    rnd_ready = 1'b1;
    for (int j = 0; j < 250; j++) begin
      for (int b = 0; b < BATCHES_PER_JOB; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(32'h1000 + addr_t'(j * JOB_LEN + b * HASH_ISSUE_WIDTH),
             (b == BATCHES_PER_JOB - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_bus.ready = '1;
    wait_drain("drain_random");
    for (int i = 0; i < NUM_JOB_PE; i++)
      check($sformatf("pe%0d_leftover", i), 256'(exp_q[i].size()), 256'(0));
    check("rand_cur_pe", 256'(cur_pe), 256'(3));
    check("rand_err_addr", 256'(err_addr), 256'(0));
    check("rand_err_delim", 256'(err_delim), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
